line_buffer_in_fifo: RTL
========================

Name: line_buffer_in_fifo

Overview:
Synchronous single-clock FIFO directly upstream of the convolution line buffer. Stores incoming pixels (all channels of one pixel per word) from the previous layer or DMA. Supplies them to the line buffer through a read-enable / registered-valid handshake. Exports an almost-full level flag that the line buffer uses to pace its reads.

Parameters:
DATA_WIDTH, 8, bits per channel sample
IN_CHANNEL, 3, channels packed per pixel word (word width PIXEL_WIDTH = DATA_WIDTH*IN_CHANNEL)
DEPTH, 64, number of pixel words stored; must be a power of 2 and >= 4
ALMOST_FULL_THRESH, 48, occupancy at or above which almost_full asserts; range 1..DEPTH

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
i_data  in  PIXEL_WIDTH  write pixel word
i_valid  in  1  write request
o_ready  out  1  not full; a write is accepted only when i_valid & o_ready
rd_en  in  1  read request from line buffer (its fifo_rd_en)
o_data  out  PIXEL_WIDTH  read pixel word, registered
o_valid  out  1  o_data holds a newly popped word this cycle (line buffer i_valid)
almost_full  out  1  occupancy >= ALMOST_FULL_THRESH (line buffer fifo_almost_full)
empty  out  1  occupancy == 0
count  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH

Behaviour:
- Storage: DEPTH x PIXEL_WIDTH array; write pointer and read pointer of clog2(DEPTH) bits wrap naturally modulo DEPTH; count register of clog2(DEPTH)+1 bits.
- Reset (rst_n low at rising edge): pointers=0, count=0, o_valid=0, o_data=0, o_ready=1, empty=1, almost_full=0. Array contents are not reset. Reset overrides any simultaneous read/write in that cycle.
- Flags derived combinationally from the registered count: o_ready = (count != DEPTH); empty = (count == 0); almost_full = (count >= ALMOST_FULL_THRESH).
- Write: if i_valid & o_ready, store i_data at wr_ptr and increment wr_ptr. If i_valid while full, the word is dropped and no state changes.
- Read: if rd_en & !empty, o_data <= mem[rd_ptr], rd_ptr increments, and o_valid = 1 in the next cycle. Read latency is 1 cycle from rd_en to o_valid.
- o_valid is high for exactly one cycle per accepted read. Back-to-back rd_en produces back-to-back o_valid.
- rd_en while empty is ignored: o_valid = 0 next cycle and o_data holds its previous value.
- o_data holds its last value whenever no read is accepted.
- Simultaneous accepted write and read: count unchanged and both pointers advance.
- No fall-through. When empty, a same-cycle write and rd_en results in the write being accepted and the read ignored.
- Full is judged on the pre-cycle count. A write while full is dropped even if a read is accepted in the same cycle.
- count changes by +1, -1 or 0 per cycle and never exceeds DEPTH or goes below 0.

Optional Feature:
Macro LB_FIFO_ERR_FLAGS_EN.
- Defined: adds outputs overflow (1 bit) and underflow (1 bit), both sticky and cleared only by reset.
  - overflow sets the cycle after i_valid & !o_ready.
  - underflow sets the cycle after rd_en & empty.
  - Both reset to 0.
- Not defined: ports absent, and dropped writes or ignored reads are silent.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles with i_valid=1 and rd_en=1 -> after release, count=0, empty=1, o_ready=1, o_valid=0, almost_full=0.
- Fill and drain order: write 0x010203..0x404142 (64 words) -> count=64, o_ready=0; read continuously -> o_valid runs 64 consecutive cycles starting 1 cycle after the first rd_en, with data in write order.
- Almost-full edge: write 47 words -> almost_full=0; write the 48th -> almost_full=1 the next cycle; one read -> almost_full=0.
- Overflow drop: with the FIFO full, write 0xAAAAAA -> count stays 64; drain 64 words -> 0xAAAAAA never appears; with LB_FIFO_ERR_FLAGS_EN, overflow=1 and stays 1.
- Empty read / simultaneous: with the FIFO empty, assert rd_en and write 0x112233 in the same cycle -> o_valid=0 next cycle and count=1; rd_en next cycle -> o_valid=1 with o_data=0x112233; with the macro, underflow=1.
- Pointer wrap: 200 cycles of random concurrent read/write with count kept between 10 and 60 -> scoreboard matches, count tracks exactly, and no o_valid occurs without a preceding accepted read.

Source files
------------

// File: rtl/line_buffer_in_fifo.sv
// Single-clock pixel FIFO feeding the convolution line buffer, with registered read data/valid.
// Optional sticky overflow/underflow outputs are enabled by defining LB_FIFO_ERR_FLAGS_EN.
module line_buffer_in_fifo #(
    parameter int DATA_WIDTH         = 8,
    parameter int IN_CHANNEL         = 3,
    parameter int DEPTH              = 64,
    parameter int ALMOST_FULL_THRESH = 48,
    localparam int PIXEL_WIDTH       = DATA_WIDTH * IN_CHANNEL,
    localparam int AW                = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PIXEL_WIDTH-1:0] i_data,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic                   rd_en,
    output logic [PIXEL_WIDTH-1:0] o_data,
    output logic                   o_valid,
    output logic                   almost_full,
    output logic                   empty,
    output logic [AW:0]            count
`ifdef LB_FIFO_ERR_FLAGS_EN
    ,
    output logic                   overflow,
    output logic                   underflow
`endif
);

    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0] THRESH_C = (AW+1)'(ALMOST_FULL_THRESH);

    logic [PIXEL_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic                   wr_accept;
    logic                   rd_accept;

    // Flags come straight from the registered count, so full/empty reflect the pre-cycle state.
    assign o_ready     = (count != DEPTH_C);
    assign empty       = (count == '0);
    assign almost_full = (count >= THRESH_C);
    assign wr_accept   = i_valid & o_ready;
    assign rd_accept   = rd_en & ~empty;

    always_ff @(posedge clk) begin
        if (rst_n && wr_accept) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            o_valid <= rd_accept;
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                o_data <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef LB_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow  | (i_valid & ~o_ready);
            underflow <= underflow | (rd_en & empty);
        end
    end
`endif

endmodule
